// File: rtl/ibis_pkg.sv
// Shared types for the ibis texel fetch path: pixel record, tile address type
// and the reserved transparent palette index.
package ibis_pkg;

   localparam int IBIS_TILE_SIZE_POW2  = 5;
   localparam int IBIS_TEXEL_WIDTH     = 8;
   localparam int IBIS_COLOR_WIDTH     = 16;
   localparam int IBIS_FIFO_DEPTH_POW2 = 2;

   localparam logic [IBIS_TEXEL_WIDTH-1:0] TRANSPARENT_INDEX = '0;

   typedef logic [2*IBIS_TILE_SIZE_POW2-1:0] tile_addr_t;

   typedef struct packed {
      logic [IBIS_COLOR_WIDTH-1:0] color;
      logic                        transparent;
   } pixel_t;

endpackage

// File: rtl/ibis_pixel_fifo.sv
// Synchronous pixel FIFO. A push into a full FIFO succeeds only when a pop
// happens on the same edge; otherwise the pixel is dropped and drop pulses.
module ibis_pixel_fifo
   import ibis_pkg::*;
#(
   parameter int DEPTH_POW2 = IBIS_FIFO_DEPTH_POW2
) (
   input  logic              aclk,
   input  logic              areset,
   input  logic              push,
   input  pixel_t            push_data,
   input  logic              pop,
   output pixel_t            head,
   output logic              full,
   output logic              empty,
   output logic [DEPTH_POW2:0] count,
   output logic              drop
);

   localparam logic [DEPTH_POW2:0] DEPTH_CNT = {1'b1, {DEPTH_POW2{1'b0}}};

   pixel_t                  mem [DEPTH_CNT];
   logic [DEPTH_POW2-1:0]   wr_ptr;
   logic [DEPTH_POW2-1:0]   rd_ptr;
   logic                    pop_ok;
   logic                    push_ok;

   assign empty   = (count == '0);
   assign full    = (count == DEPTH_CNT);
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);
   assign drop    = push & ~push_ok;
   assign head    = mem[rd_ptr];

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + DEPTH_POW2'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + DEPTH_POW2'(1);
         if (push_ok && !pop_ok)
            count <= count + (DEPTH_POW2+1)'(1);
         else if (pop_ok && !push_ok)
            count <= count - (DEPTH_POW2+1)'(1);
      end
   end

   // Storage carries no reset; entries are only visible once pushed.
   always_ff @(posedge aclk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/ibis_texel_fetch.sv
// Texel fetch: map result -> tile memory read -> palette lookup -> pixel FIFO.
// Three enable-gated stages; FIFO pop and palette writes ignore enable.
module ibis_texel_fetch
   import ibis_pkg::*;
#(
   parameter int TILE_SIZE_POW2  = IBIS_TILE_SIZE_POW2,
   parameter int TEXEL_WIDTH     = IBIS_TEXEL_WIDTH,
   parameter int COLOR_WIDTH     = IBIS_COLOR_WIDTH,
   parameter int FIFO_DEPTH_POW2 = IBIS_FIFO_DEPTH_POW2
) (
   input  logic                        aclk,
   input  logic                        areset,
   input  logic                        enable,
   input  logic                        map_valid,
   input  logic [2*TILE_SIZE_POW2-1:0] map_address,
   input  logic                        stencil_test,
   output logic                        mem_en,
   output logic [2*TILE_SIZE_POW2-1:0] mem_addr,
   input  logic [TEXEL_WIDTH-1:0]      mem_rdata,
   input  logic                        palette_we,
   input  logic [TEXEL_WIDTH-1:0]      palette_waddr,
   input  logic [COLOR_WIDTH-1:0]      palette_wdata,
   output logic                        pixel_valid,
   input  logic                        pixel_ready,
   output logic [COLOR_WIDTH-1:0]      pixel_color,
   output logic                        pixel_transparent,
   output logic                        overflow
);

   logic [COLOR_WIDTH-1:0] palette [1<<TEXEL_WIDTH];

   logic                   s1_valid, s1_trans;
   logic                   s2_valid, s2_trans;
   logic [TEXEL_WIDTH-1:0] s2_index;
   logic                   s3_valid;
   pixel_t                 s3_pix;

   pixel_t                 fifo_head;
   logic                   fifo_full, fifo_empty, fifo_drop;
   logic [FIFO_DEPTH_POW2:0] fifo_count;

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         mem_en   <= 1'b0;
         mem_addr <= '0;
         s1_valid <= 1'b0;
         s1_trans <= 1'b0;
         s2_valid <= 1'b0;
         s2_trans <= 1'b0;
         s2_index <= '0;
         s3_valid <= 1'b0;
         s3_pix   <= '0;
      end else if (enable) begin
         s1_valid <= map_valid;
         s1_trans <= map_valid & ~stencil_test;
         mem_en   <= map_valid & stencil_test;
         if (map_valid) mem_addr <= map_address;

         s2_valid <= s1_valid;
         s2_trans <= s1_trans;
         s2_index <= mem_rdata;

         // Stencil-failed texels and index 0 both become transparent black.
         s3_valid <= s2_valid;
         if (s2_trans || s2_index == TRANSPARENT_INDEX) begin
            s3_pix.color       <= '0;
            s3_pix.transparent <= 1'b1;
         end else begin
            s3_pix.color       <= palette[s2_index];
            s3_pix.transparent <= 1'b0;
         end
      end
   end

   // Palette has no reset; a same-edge lookup sees the previous contents.
   always_ff @(posedge aclk) begin
      if (palette_we) palette[palette_waddr] <= palette_wdata;
   end

   ibis_pixel_fifo #(
      .DEPTH_POW2 (FIFO_DEPTH_POW2)
   ) u_fifo (
      .aclk      (aclk),
      .areset    (areset),
      .push      (enable & s3_valid),
      .push_data (s3_pix),
      .pop       (pixel_ready),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count),
      .drop      (fifo_drop)
   );

   always_ff @(posedge aclk or posedge areset) begin
      if (areset)         overflow <= 1'b0;
      else if (fifo_drop) overflow <= 1'b1;
   end

   assign pixel_valid       = ~fifo_empty;
   assign pixel_color       = fifo_empty ? '0 : fifo_head.color;
   assign pixel_transparent = fifo_empty ? 1'b0 : fifo_head.transparent;

endmodule

// File: tb/tb_ibis_texel_fetch.sv
// Bench for ibis_texel_fetch: directed vectors, expected pixels queued at
// issue time and popped by a monitor on each accepted output.
module tb_ibis_texel_fetch;

   logic        aclk = 1'b0;
   logic        areset;
   logic        enable;
   logic        map_valid;
   logic [9:0]  map_address;
   logic        stencil_test;
   logic        mem_en;
   logic [9:0]  mem_addr;
   logic [7:0]  mem_rdata;
   logic        palette_we;
   logic [7:0]  palette_waddr;
   logic [15:0] palette_wdata;
   logic        pixel_valid;
   logic        pixel_ready;
   logic [15:0] pixel_color;
   logic        pixel_transparent;
   logic        overflow;

   logic [7:0]  tile_mem [1024];
   logic [16:0] exp_q [$];
   int          n_vec = 0;
   int          n_err = 0;

   always #5 aclk = ~aclk;

   ibis_texel_fetch dut (
      .aclk              (aclk),
      .areset            (areset),
      .enable            (enable),
      .map_valid         (map_valid),
      .map_address       (map_address),
      .stencil_test      (stencil_test),
      .mem_en            (mem_en),
      .mem_addr          (mem_addr),
      .mem_rdata         (mem_rdata),
      .palette_we        (palette_we),
      .palette_waddr     (palette_waddr),
      .palette_wdata     (palette_wdata),
      .pixel_valid       (pixel_valid),
      .pixel_ready       (pixel_ready),
      .pixel_color       (pixel_color),
      .pixel_transparent (pixel_transparent),
      .overflow          (overflow)
   );

   // Tile memory data follows the registered address in the cycle after E.
   assign mem_rdata = tile_mem[mem_addr];

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic pal_write(input logic [7:0] idx, input logic [15:0] data);
      palette_we    = 1'b1;
      palette_waddr = idx;
      palette_wdata = data;
      tick();
      palette_we    = 1'b0;
   endtask

   task automatic issue(input logic [9:0] addr, input logic st);
      map_valid    = 1'b1;
      map_address  = addr;
      stencil_test = st;
   endtask

   always @(negedge aclk) begin
      if (!areset && pixel_valid && pixel_ready) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_pixel: got color=0x%0h trans=%0b expected none",
                     pixel_color, pixel_transparent);
         end else begin
            logic [16:0] e;
            e = exp_q.pop_front();
            if ({pixel_color, pixel_transparent} !== e) begin
               n_err++;
               $display("FAIL pixel_out: got color=0x%0h trans=%0b expected color=0x%0h trans=%0b",
                        pixel_color, pixel_transparent, e[16:1], e[0]);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      areset = 1'b1; enable = 1'b1; map_valid = 1'b0; map_address = '0;
      stencil_test = 1'b0; palette_we = 1'b0; palette_waddr = '0;
      palette_wdata = '0; pixel_ready = 1'b0;
      foreach (tile_mem[i]) tile_mem[i] = 8'h00;
      tile_mem[10'h123] = 8'h05;
      tile_mem[10'h055] = 8'h05;
      tile_mem[10'h200] = 8'h00;
      tile_mem[10'h077] = 8'h07;
      for (int i = 0; i < 6; i++) tile_mem[10'h300 + i] = 8'h10 + 8'(i);

      repeat (2) @(posedge aclk);
      #1;
      check("rst_mem_en", 32'(mem_en), 0);
      check("rst_mem_addr", 32'(mem_addr), 0);
      check("rst_pixel_valid", 32'(pixel_valid), 0);
      check("rst_pixel_color", 32'(pixel_color), 0);
      check("rst_pixel_trans", 32'(pixel_transparent), 0);
      check("rst_overflow", 32'(overflow), 0);
      areset = 1'b0;
      tick();

      pal_write(8'h05, 16'hBEEF);
      pal_write(8'h00, 16'h1234);
      pal_write(8'h07, 16'h1111);
      for (int i = 0; i < 6; i++) pal_write(8'h10 + 8'(i), 16'hA000 + 16'(i));

      // Basic lookup with latency checks
      pixel_ready = 1'b1;
      issue(10'h123, 1'b1); exp_q.push_back({16'hBEEF, 1'b0});
      tick(); map_valid = 1'b0;
      check("basic_mem_en", 32'(mem_en), 1);
      check("basic_mem_addr", 32'(mem_addr), 32'h123);
      tick(); tick();
      check("basic_not_early", 32'(pixel_valid), 0);
      tick();
      check("basic_valid", 32'(pixel_valid), 1);
      check("basic_color", 32'(pixel_color), 32'hBEEF);
      repeat (2) tick();

      // Stencil fail
      issue(10'h055, 1'b0); exp_q.push_back({16'h0000, 1'b1});
      tick(); map_valid = 1'b0;
      check("stencil_mem_en", 32'(mem_en), 0);
      repeat (3) tick();
      check("stencil_valid", 32'(pixel_valid), 1);
      check("stencil_trans", 32'(pixel_transparent), 1);
      repeat (2) tick();

      // Index 0 is transparent regardless of palette[0]
      issue(10'h200, 1'b1); exp_q.push_back({16'h0000, 1'b1});
      tick(); map_valid = 1'b0;
      repeat (5) tick();

      // Palette write on the lookup edge returns the old value
      issue(10'h077, 1'b1); exp_q.push_back({16'h1111, 1'b0});
      tick(); map_valid = 1'b0;
      tick();
      palette_we = 1'b1; palette_waddr = 8'h07; palette_wdata = 16'h2222;
      tick(); palette_we = 1'b0;
      repeat (3) tick();
      issue(10'h077, 1'b1); exp_q.push_back({16'h2222, 1'b0});
      tick(); map_valid = 1'b0;
      repeat (5) tick();

      // enable=0 freezes the pipeline
      issue(10'h123, 1'b1); exp_q.push_back({16'hBEEF, 1'b0});
      tick(); map_valid = 1'b0; enable = 1'b0;
      repeat (4) tick();
      check("stall_hold", 32'(pixel_valid), 0);
      enable = 1'b1;
      tick(); tick();
      check("stall_not_early", 32'(pixel_valid), 0);
      tick();
      check("stall_resume", 32'(pixel_valid), 1);
      repeat (2) tick();

      // Back-to-back into a stalled consumer: 4 kept, then overflow
      pixel_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         issue(10'h300 + 10'(i), 1'b1);
         if (i < 4) exp_q.push_back({16'hA000 + 16'(i), 1'b0});
         tick();
      end
      map_valid = 1'b0;
      tick();
      check("ovf_before", 32'(overflow), 0);
      check("ovf_full_valid", 32'(pixel_valid), 1);
      tick();
      check("ovf_set", 32'(overflow), 1);
      repeat (2) tick();
      check("ovf_sticky", 32'(overflow), 1);
      pixel_ready = 1'b1;
      repeat (6) tick();
      check("ovf_drained", 32'(exp_q.size()), 0);
      check("ovf_empty", 32'(pixel_valid), 0);
      pixel_ready = 1'b0;

      areset = 1'b1; #1;
      check("rst_clears_ovf", 32'(overflow), 0);
      tick(); areset = 1'b0; tick();

      // Push and pop on the same edge while full
      for (int i = 0; i < 4; i++) begin
         issue(10'h300 + 10'(i), 1'b1);
         exp_q.push_back({16'hA000 + 16'(i), 1'b0});
         tick();
      end
      map_valid = 1'b0;
      repeat (4) tick();
      check("pp_full_ovf", 32'(overflow), 0);
      issue(10'h304, 1'b1); exp_q.push_back({16'hA004, 1'b0});
      tick(); map_valid = 1'b0;
      tick(); tick();
      pixel_ready = 1'b1;
      tick();
      pixel_ready = 1'b0;
      check("pp_ovf", 32'(overflow), 0);
      check("pp_valid", 32'(pixel_valid), 1);
      repeat (2) tick();
      pixel_ready = 1'b1;
      repeat (6) tick();
      check("pp_drained", 32'(exp_q.size()), 0);

      // Reset mid-flight discards the in-flight pixel
      issue(10'h123, 1'b1);
      tick(); map_valid = 1'b0;
      check("mid_mem_en_pre", 32'(mem_en), 1);
      #2 areset = 1'b1; #1;
      check("mid_mem_en", 32'(mem_en), 0);
      check("mid_pixel_valid", 32'(pixel_valid), 0);
      check("mid_overflow", 32'(overflow), 0);
      tick(); areset = 1'b0;
      repeat (6) tick();
      check("mid_no_pixel", 32'(pixel_valid), 0);
      check("final_queue", 32'(exp_q.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
